// File: rtl/sayuru_mem_if.sv
// sayuru_mem_if: core memory protocol bundle (req/gnt/rvalid).
// Ports (modports):
//   master : drives req, addr, we, be, wdata; receives gnt, rvalid, rdata
//   slave  : receives req, addr, we, be, wdata; drives gnt, rvalid, rdata
interface sayuru_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic                    rvalid;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [DATA_WIDTH-1:0]   wdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sayuru_mem_responder.sv
// sayuru_mem_responder: word-organised RAM responder for the sayuru memory protocol.
// Programmable grant delay, byte-enabled writes, in-order pipelined responses.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       sayuru_mem_if slave (req/gnt/rvalid, addr, we, be, wdata, rdata)
//   rd_count  granted read count   (only with SAYURU_MEM_STATS_EN defined)
//   wr_count  granted write count  (only with SAYURU_MEM_STATS_EN defined)
// Build option: define SAYURU_MEM_STATS_EN to add the access counters.
module sayuru_mem_responder #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int GNT_DELAY      = 0,
  parameter int RD_LATENCY     = 1
) (
  input  logic          clk,
  input  logic          rst,
  sayuru_mem_if.slave   bus
`ifdef SAYURU_MEM_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
`endif
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CNT_W = (GNT_DELAY < 1) ? 1 : $clog2(GNT_DELAY + 1);

  logic [CNT_W-1:0]          dly_cnt;
  logic                      gnt;
  logic [MEM_DEPTH_LOG2-1:0] widx;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [RD_LATENCY-1:0]     pipe_v;
  logic [DATA_WIDTH-1:0]     pipe_d [RD_LATENCY];

  // Upper address bits alias onto the array and the byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2], bus.addr[1:0]};

  assign widx = bus.addr[MEM_DEPTH_LOG2+1:2];

  // Grant is held off during reset so nothing is committed on the reset edge.
  assign gnt     = bus.req && !rst && (dly_cnt == CNT_W'(GNT_DELAY));
  assign bus.gnt = gnt;

  always_ff @(posedge clk) begin
    if (rst || !bus.req || gnt) dly_cnt <= '0;
    else                        dly_cnt <= dly_cnt + CNT_W'(1);
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (gnt && bus.we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.be[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // Each stage only loads data behind a valid entry, so the last stage (rdata)
  // holds its previous value while rvalid is low. The read at stage 0 sees the
  // array before this edge's write, i.e. everything committed on earlier edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= gnt;
      if (gnt) pipe_d[0] <= bus.we ? '0 : mem[widx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign bus.rvalid = pipe_v[RD_LATENCY-1];
  assign bus.rdata  = pipe_d[RD_LATENCY-1];

`ifdef SAYURU_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (gnt) begin
      if (bus.we) wr_count <= wr_count + 32'd1;
      else        rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sayuru_mem_responder.sv
module tb_sayuru_mem_responder;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   gnt_wait = 0;
  logic [31:0] last_rdata = '0;

  grant_t gq_a[$], gq_b[$];
  resp_t  rq_a[$], rq_b[$];
  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a: GNT_DELAY=0, RD_LATENCY=1; dut_b: GNT_DELAY=0, RD_LATENCY=3; dut_c: GNT_DELAY=3
  sayuru_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_a ();
  sayuru_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_b ();
  sayuru_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_c ();

`ifdef SAYURU_MEM_STATS_EN
  logic [31:0] rdc_a, wrc_a, rdc_b, wrc_b, rdc_c, wrc_c;
`endif

  sayuru_mem_responder #(.GNT_DELAY(0), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
`ifdef SAYURU_MEM_STATS_EN
    , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
  );
  sayuru_mem_responder #(.GNT_DELAY(0), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
`ifdef SAYURU_MEM_STATS_EN
    , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
  );
  sayuru_mem_responder #(.GNT_DELAY(3), .RD_LATENCY(1)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c)
`ifdef SAYURU_MEM_STATS_EN
    , .rd_count(rdc_c), .wr_count(wrc_c)
`endif
  );

  // Passive monitors: log every grant and every response, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.req && bus_a.gnt) gq_a.push_back('{cyc, bus_a.we, bus_a.addr, bus_a.be, bus_a.wdata});
      if (bus_a.rvalid)           rq_a.push_back('{cyc, bus_a.rdata});
      if (bus_b.req && bus_b.gnt) gq_b.push_back('{cyc, bus_b.we, bus_b.addr, bus_b.be, bus_b.wdata});
      if (bus_b.rvalid)           rq_b.push_back('{cyc, bus_b.rdata});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  task automatic drive(input int d, input bit rq, input bit we, input logic [15:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    case (d)
      0: begin bus_a.req = rq; bus_a.we = we; bus_a.addr = addr; bus_a.be = be; bus_a.wdata = wd; end
      1: begin bus_b.req = rq; bus_b.we = we; bus_b.addr = addr; bus_b.be = be; bus_b.wdata = wd; end
      default: begin bus_c.req = rq; bus_c.we = we; bus_c.addr = addr; bus_c.be = be; bus_c.wdata = wd; end
    endcase
  endtask

  function automatic bit gnt_of(input int d);
    case (d)
      0: return bus_a.gnt;
      1: return bus_b.gnt;
      default: return bus_c.gnt;
    endcase
  endfunction

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  // Presents a request and holds it until granted; returns one cycle after the
  // grant edge with req still asserted so consecutive calls run back-to-back.
  task automatic issue(input int d, input bit we, input logic [15:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    bit got = 1'b0;
    drive(d, 1'b1, we, addr, be, wd);
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = gnt_of(d);
      if (got) gnt_wait = i;
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout dut%0d addr=%h: got no gnt, required gnt within 16 cycles", d, addr);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    gq_a.delete(); gq_b.delete(); rq_a.delete(); rq_b.delete();
  endtask

  // Replays logged grants in order through the word/byte model and matches
  // them against logged responses (data and grant-to-rvalid latency).
  task automatic check_resp(input int d, input string name);
    grant_t g;
    resp_t  r;
    logic [31:0] exp;
    bit kn, got;
    int idx, rl, left;
    rl = (d == 0) ? 1 : 3;
    idle(d);
    repeat (rl + 3) @(posedge clk);
    #1;
    forever begin
      if (d == 0) begin
        if (gq_a.size() == 0) break;
        g = gq_a.pop_front();
      end else begin
        if (gq_b.size() == 0) break;
        g = gq_b.pop_front();
      end
      idx = (int'(g.addr) / 4) % 1024;
      if (g.we) begin
        for (int b = 0; b < 4; b++)
          if (g.be[b]) mdl[d][idx][8*b +: 8] = g.wdata[8*b +: 8];
        known[d][idx] = 1'b1;
        kn  = 1'b1;
        exp = 32'h0;
      end else begin
        kn  = known[d][idx];
        exp = mdl[d][idx];
      end
      got = (d == 0) ? (rq_a.size() > 0) : (rq_b.size() > 0);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL %s resp_missing dut%0d addr=%h: got none, required one at cycle %0d", name, d, g.addr, g.cyc + rl);
      end else begin
        r = (d == 0) ? rq_a.pop_front() : rq_b.pop_front();
        if (r.cyc !== g.cyc + rl || (kn && r.data !== exp)) begin
          errors++;
          $display("FAIL %s resp dut%0d addr=%h we=%0b: got data=%h cyc=%0d, required data=%h cyc=%0d",
                   name, d, g.addr, g.we, r.data, r.cyc, exp, g.cyc + rl);
        end
        if (!g.we) last_rdata = r.data;
      end
    end
    left = (d == 0) ? rq_a.size() : rq_b.size();
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL %s unexpected_resp dut%0d: got %0d extra responses, required 0", name, d, left);
    end
    if (d == 0) rq_a.delete(); else rq_b.delete();
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 1'b1, 16'h0100, 4'hF, 32'h1);
    drive(1, 1'b1, 1'b0, 16'h0100, 4'hF, 32'h1);
    drive(2, 1'b1, 1'b0, 16'h0100, 4'hF, 32'h1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.gnt !== 1'b0 || bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_a: got gnt=%b rvalid=%b rdata=%h, required 0 0 00000000", bus_a.gnt, bus_a.rvalid, bus_a.rdata);
    end
    checks++;
    if (bus_b.gnt !== 1'b0 || bus_b.rvalid !== 1'b0 || bus_b.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_b: got gnt=%b rvalid=%b rdata=%h, required 0 0 00000000", bus_b.gnt, bus_b.rvalid, bus_b.rdata);
    end
`ifdef SAYURU_MEM_STATS_EN
    checks++;
    if (rdc_a !== 32'd0 || wrc_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got rd=%0d wr=%0d, required 0 0", rdc_a, wrc_a);
    end
`endif
    idle(0); idle(1); idle(2);
    @(posedge clk);
    do_reset(1);
  endtask

  task automatic test_basic_rw();
    issue(0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    issue(0, 1'b0, 16'h0010, 4'h0, 32'h0);
    checks++;
    if (gnt_wait !== 0) begin
      errors++;
      $display("FAIL t1_gnt_same_cycle: got wait=%0d, required 0", gnt_wait);
    end
    check_resp(0, "t1");
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_rdata: got %h, required deadbeef", last_rdata);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_rdata_hold: got rvalid=%b rdata=%h, required 0 deadbeef", bus_a.rvalid, bus_a.rdata);
    end
  endtask

  task automatic test_byte_enable();
    @(posedge clk); #1;
    issue(0, 1'b1, 16'h0020, 4'hF, 32'h11223344);
    issue(0, 1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD);
    issue(0, 1'b1, 16'h0020, 4'b0000, 32'hFFFFFFFF);
    issue(0, 1'b0, 16'h0020, 4'h0, 32'h0);
    check_resp(0, "t2");
    checks++;
    if (last_rdata !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL t2_byte_merge: got %h, required 11bb33dd", last_rdata);
    end
  endtask

  task automatic test_alias();
    @(posedge clk); #1;
    issue(0, 1'b1, 16'h1004, 4'hF, 32'h5A5A5A5A);
    issue(0, 1'b0, 16'h0007, 4'h0, 32'h0);
    check_resp(0, "t5");
    checks++;
    if (last_rdata !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL t5_alias: got %h, required 5a5a5a5a", last_rdata);
    end
  endtask

  task automatic test_gnt_delay();
    int n;
    bit g;
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 16'h0, 4'h0, 32'h0);
    n = -1;
    for (int i = 0; i < 10 && n < 0; i++) begin
      @(negedge clk);
      if (bus_c.gnt) n = i;
      @(posedge clk); #1;
    end
    idle(2);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL t3_first_gnt: got gnt at req cycle %0d, required 3", n);
    end
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 16'h0, 4'h0, 32'h0);
    g = 1'b0;
    repeat (2) begin
      @(negedge clk);
      g = g | bus_c.gnt;
      @(posedge clk); #1;
    end
    idle(2);
    checks++;
    if (g !== 1'b0) begin
      errors++;
      $display("FAIL t3_early_gnt: got gnt=1 within 2 cycles, required 0");
    end
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 16'h0, 4'h0, 32'h0);
    n = -1;
    for (int i = 0; i < 10 && n < 0; i++) begin
      @(negedge clk);
      if (bus_c.gnt) n = i;
      @(posedge clk); #1;
    end
    idle(2);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL t3_regnt: got gnt at req cycle %0d, required 3", n);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) issue(1, 1'b1, 16'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i * 17));
    check_resp(1, "t4_wr");
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) issue(1, 1'b0, 16'(i * 4), 4'h0, 32'h0);
    ok = (gq_b.size() == 8);
    if (ok) begin
      c0 = gq_b[0].cyc;
      for (int i = 1; i < 8; i++) if (gq_b[i].cyc != c0 + i) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t4_b2b_grants: got %0d grants not on consecutive cycles, required 8 consecutive", gq_b.size());
    end
    check_resp(1, "t4_rd");
`ifdef SAYURU_MEM_STATS_EN
    checks++;
    if (rdc_b !== 32'd8 || wrc_b !== 32'd8) begin
      errors++;
      $display("FAIL t4_stats: got rd=%0d wr=%0d, required 8 8", rdc_b, wrc_b);
    end
`endif
  endtask

  task automatic test_reset_inflight();
    bit seen = 1'b0;
    @(posedge clk); #1;
    issue(1, 1'b0, 16'h0000, 4'h0, 32'h0);
    issue(1, 1'b0, 16'h0004, 4'h0, 32'h0);
    idle(1);
    do_reset(1);
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus_b.rvalid;
    end
    checks++;
    if (seen || rq_b.size() != 0) begin
      errors++;
      $display("FAIL t6_no_rvalid: got rvalid after reset (%0d logged), required none", rq_b.size());
    end
`ifdef SAYURU_MEM_STATS_EN
    checks++;
    if (rdc_b !== 32'd0 || wrc_b !== 32'd0) begin
      errors++;
      $display("FAIL t6_stats_clear: got rd=%0d wr=%0d, required 0 0", rdc_b, wrc_b);
    end
`endif
    // A write presented while reset is asserted must not reach the array.
    @(posedge clk); #1;
    issue(0, 1'b1, 16'h0040, 4'hF, 32'hCAFEF00D);
    check_resp(0, "t6_pre");
    drive(0, 1'b1, 1'b1, 16'h0040, 4'hF, 32'h12345678);
    do_reset(1);
    idle(0);
    @(posedge clk); #1;
    issue(0, 1'b0, 16'h0040, 4'h0, 32'h0);
    check_resp(0, "t6_rst_write");
    checks++;
    if (last_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL t6_rst_write: got %h, required cafef00d", last_rdata);
    end
  endtask

  task automatic test_random(input int d);
    logic [15:0] a;
    int w;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) issue(d, 1'b1, 16'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 15);
      a = 16'($urandom_range(0, 15) << 12) | 16'(w << 2) | 16'($urandom_range(0, 3));
      issue(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        idle(d);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    check_resp(d, (d == 0) ? "rand_a" : "rand_b");
  endtask

  initial begin
    idle(0); idle(1); idle(2);
    test_reset();
    test_basic_rw();
    test_byte_enable();
    test_alias();
    test_gnt_delay();
    test_back_to_back();
    test_reset_inflight();
    test_random(0);
    test_random(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
